// File: rtl/serv_state_wide.sv
// Control/state sequencer for a WIDTH-bit-per-cycle SERV datapath.
// Runs an optional INIT stage and an execute stage, each lasting 32/WIDTH counter cycles.
module serv_state_wide #(
  parameter int unsigned WIDTH    = 1,
  parameter bit          WITH_CSR = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_new_irq,
  output logic       o_ibus_cyc,
  input  logic       i_ibus_ack,
  output logic       o_dbus_cyc,
  input  logic       i_dbus_ack,
  output logic       o_rf_rreq,
  output logic       o_rf_wreq,
  input  logic       i_rf_ready,
  output logic       o_rf_rd_en,
  input  logic       i_branch_op,
  input  logic       i_cond_branch,
  input  logic       i_cmp_true,
  input  logic       i_mem_op,
  input  logic       i_shift_op,
  input  logic       i_slt_op,
  input  logic       i_e_op,
  input  logic       i_rd_op,
  input  logic       i_sh_done,
  input  logic       i_ctrl_misalign,
  input  logic       i_mem_misalign,
  output logic       o_init,
  output logic       o_cnt_en,
  output logic [4:0] o_cnt,
  output logic       o_cnt_done,
  output logic [1:0] o_mem_bytecnt,
  output logic       o_ctrl_pc_en,
  output logic       o_ctrl_jump,
  output logic       o_ctrl_trap,
  output logic       o_bufreg_en
);

  localparam logic [4:0] CntStep = 5'(WIDTH);
  localparam logic [4:0] CntLast = 5'(32 - WIDTH);

  logic [4:0] r_cnt;
  logic       r_cnt_en;
  logic       r_init_done;
  logic       r_ctrl_jump;
  logic       r_misalign_trap;
  logic       r_stage_two_req;
  logic       r_ibus_cyc;

  logic       w_two_stage;
  logic       w_take_branch;
  logic       w_misalign_now;

  assign w_two_stage    = i_slt_op | i_mem_op | i_branch_op | i_shift_op;
  assign w_take_branch  = i_branch_op & (~i_cond_branch | i_cmp_true);
  // Misalignment is only ever trapped when CSR support exists.
  assign w_misalign_now = WITH_CSR & o_init &
                          ((w_take_branch & i_ctrl_misalign) | (i_mem_op & i_mem_misalign));

  assign o_init        = w_two_stage & ~i_new_irq & ~r_init_done;
  assign o_cnt_en      = r_cnt_en;
  assign o_cnt         = r_cnt;
  assign o_cnt_done    = r_cnt_en & (r_cnt == CntLast);
  assign o_mem_bytecnt = r_cnt[4:3];
  assign o_ctrl_pc_en  = r_cnt_en & ~o_init;
  assign o_ctrl_jump   = r_ctrl_jump;
  assign o_ctrl_trap   = WITH_CSR & (i_e_op | i_new_irq | r_misalign_trap);
  assign o_rf_rd_en    = i_rd_op & ~o_init;
  assign o_ibus_cyc    = r_ibus_cyc & i_rst_n;

  assign o_dbus_cyc = ~r_cnt_en & r_init_done & i_mem_op & ~i_mem_misalign;

  assign o_rf_rreq = i_ibus_ack | (r_stage_two_req & r_misalign_trap);

  assign o_rf_wreq = ~r_misalign_trap &
                     ((i_shift_op & i_sh_done & ~r_cnt_en & r_init_done) |
                      (i_mem_op & i_dbus_ack) |
                      (r_stage_two_req & (i_slt_op | i_branch_op)));

  // Shift phase between stages keeps the bufreg moving until the shifter reports done.
  assign o_bufreg_en = (r_cnt_en & (o_init | o_ctrl_trap | i_branch_op)) |
                       (i_shift_op & ~r_stage_two_req & ~r_cnt_en & r_init_done & ~i_sh_done);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_cnt_en <= 1'b0;
    end else if (r_cnt_en) begin
      r_cnt <= r_cnt + CntStep;
      if (o_cnt_done) begin
        r_cnt_en <= 1'b0;
      end
    end else begin
      r_cnt <= '0;
      if (i_rf_ready) begin
        r_cnt_en <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_init_done     <= 1'b0;
      r_ctrl_jump     <= 1'b0;
      r_misalign_trap <= 1'b0;
      r_stage_two_req <= 1'b0;
    end else begin
      if (o_cnt_done) begin
        r_init_done     <= o_init & ~r_init_done;
        r_ctrl_jump     <= o_init & w_take_branch;
        r_misalign_trap <= w_misalign_now;
      end
      r_stage_two_req <= o_cnt_done & o_init;
    end
  end

  // Fetch request: set priority over ack when both land in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ibus_cyc <= 1'b1;
    end else if (o_cnt_done & o_ctrl_pc_en) begin
      r_ibus_cyc <= 1'b1;
    end else if (i_ibus_ack) begin
      r_ibus_cyc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serv_state_wide.sv
// Directed bench for serv_state_wide: one instance per WIDTH plus a WITH_CSR=0 instance,
// all sharing the same stimulus; counter sequences are checked against a queued scoreboard.
module tb_serv_state_wide;

  typedef struct packed {
    logic       ibus_cyc;
    logic       dbus_cyc;
    logic       rf_rreq;
    logic       rf_wreq;
    logic       rf_rd_en;
    logic       init;
    logic       cnt_en;
    logic [4:0] cnt;
    logic       cnt_done;
    logic [1:0] bytecnt;
    logic       pc_en;
    logic       jump;
    logic       trap;
    logic       bufreg_en;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic new_irq = 0, ibus_ack = 0, dbus_ack = 0, rf_ready = 0;
  logic branch_op = 0, cond_branch = 0, cmp_true = 0, mem_op = 0, shift_op = 0;
  logic slt_op = 0, e_op = 0, rd_op = 0, sh_done = 0, ctrl_misalign = 0, mem_misalign = 0;

  outs_t ow1, ow2, ow4, ow8, onc;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

`define SSW_INST(NAME, W, CSR, O) \
  serv_state_wide #(.WIDTH(W), .WITH_CSR(CSR)) NAME ( \
    .i_clk(clk), .i_rst_n(rst_n), .i_new_irq(new_irq), .o_ibus_cyc(O.ibus_cyc), \
    .i_ibus_ack(ibus_ack), .o_dbus_cyc(O.dbus_cyc), .i_dbus_ack(dbus_ack), \
    .o_rf_rreq(O.rf_rreq), .o_rf_wreq(O.rf_wreq), .i_rf_ready(rf_ready), \
    .o_rf_rd_en(O.rf_rd_en), .i_branch_op(branch_op), .i_cond_branch(cond_branch), \
    .i_cmp_true(cmp_true), .i_mem_op(mem_op), .i_shift_op(shift_op), .i_slt_op(slt_op), \
    .i_e_op(e_op), .i_rd_op(rd_op), .i_sh_done(sh_done), .i_ctrl_misalign(ctrl_misalign), \
    .i_mem_misalign(mem_misalign), .o_init(O.init), .o_cnt_en(O.cnt_en), .o_cnt(O.cnt), \
    .o_cnt_done(O.cnt_done), .o_mem_bytecnt(O.bytecnt), .o_ctrl_pc_en(O.pc_en), \
    .o_ctrl_jump(O.jump), .o_ctrl_trap(O.trap), .o_bufreg_en(O.bufreg_en));

  `SSW_INST(u_w1, 1, 1'b1, ow1)
  `SSW_INST(u_w2, 2, 1'b1, ow2)
  `SSW_INST(u_w4, 4, 1'b1, ow4)
  `SSW_INST(u_w8, 8, 1'b1, ow8)
  `SSW_INST(u_nocsr, 4, 1'b0, onc)

  function automatic outs_t sel(input int w);
    case (w)
      1:       return ow1;
      2:       return ow2;
      4:       return ow4;
      8:       return ow8;
      default: return onc;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    new_irq = 0; branch_op = 0; cond_branch = 0; cmp_true = 0; mem_op = 0; shift_op = 0;
    slt_op = 0; e_op = 0; rd_op = 0; sh_done = 0; ctrl_misalign = 0; mem_misalign = 0;
    ibus_ack = 0; dbus_ack = 0; rf_ready = 0;
  endtask

  // Reset, then consume the post-reset fetch so ibus_cyc starts low.
  task automatic start_instr();
    clear_ops();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    ibus_ack = 1;
    tick();
    ibus_ack = 0;
  endtask

  task automatic run_stage(input int w, input logic exp_init, input logic exp_bufreg);
    outs_t o;
    logic [4:0] e;
    int guard;
    int idx;
    for (int c = 0; c < 32; c += w) begin
      e = c[4:0];
      exp_q.push_back(e);
    end
    o = sel(w);
    check($sformatf("w%0d_idle_cnt_en", w), o.cnt_en, 0);
    rf_ready = 1;
    tick();
    rf_ready = 0;
    guard = 0;
    idx = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      o = sel(w);
      if (o.cnt_en) begin
        e = exp_q.pop_front();
        check($sformatf("w%0d_cnt", w), o.cnt, e);
        check($sformatf("w%0d_cnt_done", w), o.cnt_done, e == 5'(32 - w));
        check($sformatf("w%0d_bytecnt", w), o.bytecnt, e[4:3]);
        check($sformatf("w%0d_init", w), o.init, exp_init);
        check($sformatf("w%0d_pc_en", w), o.pc_en, !exp_init);
        check($sformatf("w%0d_bufreg_en", w), o.bufreg_en, exp_bufreg);
        // A ready pulse mid-stage must be ignored.
        rf_ready = (idx == 2);
        idx++;
      end
      tick();
      rf_ready = 0;
      guard++;
    end
    check($sformatf("w%0d_stage_len_left", w), exp_q.size(), 0);
    exp_q.delete();
    o = sel(w);
    check($sformatf("w%0d_cnt_en_after", w), o.cnt_en, 0);
    check($sformatf("w%0d_cnt_after", w), o.cnt, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // Reset and first fetch, WIDTH=1
    #1;
    check("rst_ibus_cyc", ow1.ibus_cyc, 0);
    check("rst_cnt", ow1.cnt, 0);
    check("rst_cnt_en", ow1.cnt_en, 0);
    tick();
    rst_n = 1;
    tick();
    check("rel_ibus_cyc", ow1.ibus_cyc, 1);
    ibus_ack = 1;
    #1;
    check("ack_rf_rreq", ow1.rf_rreq, 1);
    tick();
    ibus_ack = 0;
    check("ack_ibus_clr", ow1.ibus_cyc, 0);

    // WIDTH=4 ADD
    start_instr();
    rd_op = 1;
    #1;
    check("add_rd_en", ow4.rf_rd_en, 1);
    check("add_init", ow4.init, 0);
    check("add_ibus_before", ow4.ibus_cyc, 0);
    run_stage(4, 1'b0, 1'b0);
    check("add_ibus_after", ow4.ibus_cyc, 1);
    check("add_wreq", ow4.rf_wreq, 0);

    // WIDTH=2 taken aligned BEQ
    start_instr();
    branch_op = 1; cond_branch = 1; cmp_true = 1; rd_op = 1;
    #1;
    check("beq_rd_en_init", ow2.rf_rd_en, 0);
    run_stage(2, 1'b1, 1'b1);
    check("beq_init_after", ow2.init, 0);
    check("beq_wreq", ow2.rf_wreq, 1);
    check("beq_rreq", ow2.rf_rreq, 0);
    check("beq_jump", ow2.jump, 1);
    check("beq_ibus_mid", ow2.ibus_cyc, 0);
    tick();
    check("beq_wreq_strobe", ow2.rf_wreq, 0);
    run_stage(2, 1'b0, 1'b1);
    check("beq_ibus_after", ow2.ibus_cyc, 1);
    check("beq_jump_clr", ow2.jump, 0);
    check("beq_init_again", ow2.init, 1);

    // WIDTH=8 misaligned load
    start_instr();
    mem_op = 1; mem_misalign = 1; rd_op = 1;
    #1;
    check("ld_dbus_init", ow8.dbus_cyc, 0);
    run_stage(8, 1'b1, 1'b1);
    check("ld_dbus", ow8.dbus_cyc, 0);
    check("ld_rreq", ow8.rf_rreq, 1);
    check("ld_trap", ow8.trap, 1);
    check("ld_wreq", ow8.rf_wreq, 0);
    dbus_ack = 1;
    #1;
    check("ld_wreq_ack", ow8.rf_wreq, 0);
    dbus_ack = 0;
    mem_misalign = 0;
    #1;
    check("ld_dbus_aligned", ow8.dbus_cyc, 1);
    mem_misalign = 1;
    tick();
    check("ld_rreq_strobe", ow8.rf_rreq, 0);
    check("ld_trap_hold", ow8.trap, 1);

    // Interrupt with a two-stage op, WIDTH=4
    start_instr();
    branch_op = 1; new_irq = 1;
    #1;
    check("irq_init", ow4.init, 0);
    check("irq_trap", ow4.trap, 1);
    check("irq_nocsr_trap", onc.trap, 0);
    run_stage(4, 1'b0, 1'b1);
    check("irq_ibus", ow4.ibus_cyc, 1);
    check("irq_wreq", ow4.rf_wreq, 0);
    check("irq_nocsr_trap2", onc.trap, 0);
    new_irq = 0;
    #1;
    check("irq_no_init_done", ow4.init, 1);
    e_op = 1;
    #1;
    check("eop_trap", ow4.trap, 1);
    check("eop_nocsr_trap", onc.trap, 0);

    // Asynchronous reset mid-stage, WIDTH=4
    start_instr();
    rd_op = 1;
    rf_ready = 1;
    tick();
    rf_ready = 0;
    tick();
    tick();
    tick();
    check("arst_cnt_pre", ow4.cnt, 12);
    #2;
    rst_n = 0;
    #1;
    check("arst_cnt", ow4.cnt, 0);
    check("arst_cnt_en", ow4.cnt_en, 0);
    check("arst_pc_en", ow4.pc_en, 0);
    check("arst_ibus", ow4.ibus_cyc, 0);
    check("arst_done", ow4.cnt_done, 0);
    rst_n = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serv_state_wide.md
# serv_state_wide

Width-parametrised successor to the SERV control/state sequencer, processing WIDTH bits per cycle instead of one. It sits between the decoder, register-file interface, bufreg/ALU/shift datapath and the ibus/dbus masters. It sequences each instruction through an optional INIT stage and an execute stage, generating the bit counter, bus strobes, RF request strobes, jump/trap controls and bufreg enable.

## Interface
- WIDTH, 1: bits processed per cycle; legal values 1, 2, 4, 8. A stage lasts 32/WIDTH cycles.
- WITH_CSR, 1: when 0, o_ctrl_trap is tied 0 and no misalign trap is ever raised.
- i_clk  in  1  clock; all registers update on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_new_irq  in  1  pending interrupt; suppresses INIT and forces trap
- o_ibus_cyc  out  1  instruction fetch request
- i_ibus_ack  in  1  fetch complete, instruction valid
- o_dbus_cyc  out  1  data bus request
- i_dbus_ack  in  1  data bus complete
- o_rf_rreq  out  1  RF read-prepare strobe (1 cycle)
- o_rf_wreq  out  1  RF write-prepare strobe (1 cycle)
- i_rf_ready  in  1  RF ready; starts the counter
- o_rf_rd_en  out  1  rd write enable
- i_branch_op, i_cond_branch, i_cmp_true  in  1 each  branch class, conditional flag, decoded compare result (beq/bne polarity already applied)
- i_mem_op, i_shift_op, i_slt_op, i_e_op, i_rd_op  in  1 each  decoder class flags
- i_sh_done  in  1  shifter finished
- i_ctrl_misalign, i_mem_misalign  in  1 each  jump target / memory address misaligned
- o_init  out  1  current stage is INIT
- o_cnt_en  out  1  counter running
- o_cnt  out  5  index of lowest bit handled this cycle (multiple of WIDTH)
- o_cnt_done  out  1  last cycle of a stage
- o_mem_bytecnt  out  2  o_cnt[4:3]
- o_ctrl_pc_en  out  1  PC update enable
- o_ctrl_jump  out  1  registered take-branch
- o_ctrl_trap  out  1  trap in progress
- o_bufreg_en  out  1  bufreg shift enable

## Operation
- two_stage = i_slt_op|i_mem_op|i_branch_op|i_shift_op. o_init = two_stage & !i_new_irq & !init_done.
- Counter: while idle (!o_cnt_en), i_rf_ready sets cnt_en next cycle with o_cnt=0. Each enabled cycle o_cnt += WIDTH (mod 32). o_cnt_done = o_cnt_en & (o_cnt == 32-WIDTH). The cycle after done: cnt_en=0, o_cnt=0.
- On o_cnt_done: init_done <= o_init & !init_done; o_ctrl_jump <= o_init & take_branch, where take_branch = i_branch_op & (!i_cond_branch | i_cmp_true); misalign_trap <= o_init & ((take_branch & i_ctrl_misalign) | (i_mem_op & i_mem_misalign)) (WITH_CSR=1 only).
- stage_two_req <= o_cnt_done & o_init (1-cycle strobe).
- o_rf_rreq = i_ibus_ack | (stage_two_req & misalign_trap).
- o_rf_wreq = !misalign_trap & ((i_shift_op & i_sh_done & !o_cnt_en & init_done) | (i_mem_op & i_dbus_ack) | (stage_two_req & (i_slt_op|i_branch_op))).
- o_dbus_cyc = !o_cnt_en & init_done & i_mem_op & !i_mem_misalign.
- o_ctrl_pc_en = o_cnt_en & !o_init. o_rf_rd_en = i_rd_op & !o_init. o_ctrl_trap = WITH_CSR & (i_e_op|i_new_irq|misalign_trap).
- o_bufreg_en = (o_cnt_en & (o_init|o_ctrl_trap|i_branch_op)) | (i_shift_op & !stage_two_req & !o_cnt_en & init_done & !i_sh_done).
- ibus_cyc register: set on o_cnt_done & o_ctrl_pc_en; cleared on i_ibus_ack. Done and ack in the same cycle give set priority. o_ibus_cyc = ibus_cyc & i_rst_n.

## Timing
- Reset (async assert, sync release): o_cnt=0, cnt_en=0, init_done=0, o_ctrl_jump=0, misalign_trap=0, stage_two_req=0, ibus_cyc=1. Hence o_ibus_cyc=0 during reset and 1 from the first edge after release.
- Reset asserted mid-stage aborts the stage immediately; there is no partial completion.
- Counter start latency is 1 cycle after i_rf_ready. A stage lasts exactly 32/WIDTH cycles with o_cnt_en high.
- i_rf_ready while o_cnt_en=1 is ignored.
- A one-stage instruction sets o_ibus_cyc on the cycle after o_cnt_done. A two-stage instruction sets it only after the execute stage.

## Test plan
- Reset release, WIDTH=1: o_ibus_cyc=1 on the first edge. Ack -> o_rf_rreq=1 for that cycle and o_ibus_cyc=0 on the next.
- WIDTH=4 ADD: i_rf_ready pulse -> o_cnt_en high for 8 cycles with o_cnt=0,4,…,28. o_cnt_done only at 28, o_ctrl_pc_en high throughout, o_ibus_cyc=1 the cycle after.
- WIDTH=2 taken aligned BEQ (i_cmp_true=1): 16-cycle INIT with o_init=1, then stage_two_req -> o_rf_wreq, o_ctrl_jump=1. Execute stage of 16 cycles has o_bufreg_en=1.
- WIDTH=8 misaligned load: INIT of 4 cycles, then o_dbus_cyc=0, o_rf_rreq pulse, o_ctrl_trap=1, o_rf_wreq never asserted.
- i_new_irq with two-stage op: o_init=0, o_ctrl_trap=1, single stage only. WITH_CSR=0: o_ctrl_trap=0 in all cases.
- i_rst_n low at o_cnt=12 (WIDTH=4): all outputs take reset values asynchronously, before the next clock edge.
